// File: rtl/pixel_ram_pkg.sv
// Shared constants and state type for the pixel-RAM write path.
// Used by the writer, the VGA read side and the testbench.
package pixel_ram_pkg;

    localparam int H_RES        = 640;
    localparam int V_RES        = 480;
    localparam int FRAME_PIXELS = H_RES * V_RES;
    localparam int ADDR_W       = 20;
    localparam int X_W          = 10;
    localparam int Y_W          = 9;
    localparam int DATA_W       = 8;
    localparam int CNT_W        = 16;

    typedef enum logic {
        RUN   = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // Saturating increment for the dropped-request counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

endpackage

// File: rtl/pixel_addr_calc.sv
// Combinational (x, y) to linear frame address conversion with range check.
module pixel_addr_calc
    import pixel_ram_pkg::*;
#(
    parameter int H_RES  = pixel_ram_pkg::H_RES,
    parameter int V_RES  = pixel_ram_pkg::V_RES,
    parameter int ADDR_W = pixel_ram_pkg::ADDR_W
) (
    input  logic [X_W-1:0]    x,
    input  logic [Y_W-1:0]    y,
    output logic [ADDR_W-1:0] addr,
    output logic              in_range
);

    // Constant multiply; for 640 synthesis reduces this to (y<<9)+(y<<7).
    always_comb begin
        addr     = ADDR_W'(y) * ADDR_W'(H_RES) + ADDR_W'(x);
        in_range = (int'(x) < H_RES) && (int'(y) < V_RES);
    end

endmodule

// File: rtl/pixel_ram_writer.sv
// Feeds the VGA pixel-RAM write port from a valid/ready pixel stream,
// with a hardware full-frame clear sweep that back-pressures the source.
module pixel_ram_writer
    import pixel_ram_pkg::*;
#(
    parameter int H_RES  = pixel_ram_pkg::H_RES,
    parameter int V_RES  = pixel_ram_pkg::V_RES,
    parameter int ADDR_W = pixel_ram_pkg::ADDR_W
) (
    input  logic                sys_clk,
    input  logic                reset_n,
    input  logic                pix_valid,
    output logic                pix_ready,
    input  logic [X_W-1:0]      pix_x,
    input  logic [Y_W-1:0]      pix_y,
    input  logic [DATA_W-1:0]   pix_color,
    input  logic                clear_req,
    input  logic [DATA_W-1:0]   clear_color,
    output logic                busy,
    output logic [CNT_W-1:0]    oob_count,
    output logic [DATA_W-1:0]   pr_data,
    output logic [ADDR_W-1:0]   pr_wraddress,
    output logic                pr_wren
);

    localparam int                FRAME     = H_RES * V_RES;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME - 1);

    state_t              state;
    logic                s1_valid;
    logic [ADDR_W-1:0]   s1_addr;
    logic [DATA_W-1:0]   s1_data;
    logic [ADDR_W-1:0]   clr_cnt;
    logic [DATA_W-1:0]   clr_color;
    logic [ADDR_W-1:0]   calc_addr;
    logic                calc_in_range;
    logic                accept;

    pixel_addr_calc #(
        .H_RES  (H_RES),
        .V_RES  (V_RES),
        .ADDR_W (ADDR_W)
    ) u_addr_calc (
        .x        (pix_x),
        .y        (pix_y),
        .addr     (calc_addr),
        .in_range (calc_in_range)
    );

    assign pix_ready = (state == RUN);
    assign accept    = pix_valid & pix_ready;
    assign busy      = (state == CLEAR) | s1_valid | pr_wren;

    // Mode FSM, clear sweep counter, stage-1 register and drop counter.
    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            state     <= RUN;
            s1_valid  <= 1'b0;
            s1_addr   <= {ADDR_W{1'b0}};
            s1_data   <= {DATA_W{1'b0}};
            clr_cnt   <= {ADDR_W{1'b0}};
            clr_color <= {DATA_W{1'b0}};
            oob_count <= {CNT_W{1'b0}};
        end else begin
            case (state)
                RUN: begin
                    // An accepted pixel still lands in stage 1 on the clear edge,
                    // so it reaches the RAM ahead of the sweep.
                    s1_valid <= accept & calc_in_range;
                    if (accept & calc_in_range) begin
                        s1_addr <= calc_addr;
                        s1_data <= pix_color;
                    end
                    if (accept & ~calc_in_range) begin
                        oob_count <= sat_inc(oob_count);
                    end
                    if (clear_req) begin
                        state     <= CLEAR;
                        clr_cnt   <= {ADDR_W{1'b0}};
                        clr_color <= clear_color;
                    end
                end
                CLEAR: begin
                    s1_valid <= 1'b1;
                    s1_addr  <= clr_cnt;
                    s1_data  <= clr_color;
                    if (clr_cnt == LAST_ADDR) begin
                        state   <= RUN;
                        clr_cnt <= {ADDR_W{1'b0}};
                    end else begin
                        clr_cnt <= clr_cnt + ADDR_W'(1);
                    end
                end
                default: begin
                    state    <= RUN;
                    s1_valid <= 1'b0;
                end
            endcase
        end
    end

    // Stage 2: registered RAM write port.
    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            pr_wren      <= 1'b0;
            pr_wraddress <= {ADDR_W{1'b0}};
            pr_data      <= {DATA_W{1'b0}};
        end else begin
            pr_wren      <= s1_valid;
            pr_wraddress <= s1_addr;
            pr_data      <= s1_data;
        end
    end

endmodule
